// File: rtl/repeated_mask_gen.sv
// Streams tiled sensor-mask rows: a PAT_MAX x PAT_MAX (max) binary pattern is
// repeated across IMG_W columns and down repeat_rows rows, one row per handshake.
module repeated_mask_gen #(
    parameter  int IMG_W   = 300,
    parameter  int IMG_H   = 300,
    parameter  int PAT_MAX = 5,
    localparam int PW      = $clog2(PAT_MAX + 1),
    localparam int RW      = $clog2(IMG_H + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clk_en,
    input  logic                       cfg_valid,
    input  logic [PW-1:0]              pattern_w,
    input  logic [PW-1:0]              pattern_h,
    input  logic [PAT_MAX*PAT_MAX-1:0] pattern,
    input  logic [RW-1:0]              repeat_rows,
    output logic                       cfg_ready,
    output logic                       cfg_err,
    output logic [IMG_W-1:0]           rp_mask_bit,
    output logic                       rp_valid,
    output logic                       rp_last,
    output logic [RW-1:0]              rp_row_idx,
    input  logic                       rp_ready
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                       state_q;
    logic [PAT_MAX*PAT_MAX-1:0]   pat_q;
    logic [PW-1:0]                pw_q;
    logic [PW-1:0]                ph_q;
    logic [PW-1:0]                pr_q;
    logic [RW-1:0]                rows_q;
    logic [RW-1:0]                row_idx_q;
    logic [IMG_W-1:0]             mask_q;
    logic                         valid_q;
    logic                         last_q;
    logic                         err_q;

    logic                         cfg_legal;
    logic                         cfg_fire;
    logic                         row_fire;
    logic [PW-1:0]                pr_d;
    logic [RW-1:0]                row_idx_d;
    logic [PAT_MAX*PAT_MAX-1:0]   src_pat;
    logic [PW-1:0]                src_w;
    logic [PW-1:0]                src_pr;
    logic [PAT_MAX-1:0]           pat_row [PAT_MAX];
    logic [PAT_MAX-1:0]           src_row;
    logic [IMG_W-1:0]             tile_w  [PAT_MAX];
    logic [IMG_W-1:0]             mask_d;

    assign cfg_legal = (pattern_w != '0) && (pattern_w <= PW'(PAT_MAX)) &&
                       (pattern_h != '0) && (pattern_h <= PW'(PAT_MAX)) &&
                       (repeat_rows != '0) && (repeat_rows <= RW'(IMG_H));
    assign cfg_fire  = clk_en && cfg_valid && (state_q == S_IDLE);
    assign row_fire  = clk_en && valid_q && rp_ready;

    // Pattern-row counter wraps at pattern_h instead of computing i mod h.
    assign pr_d      = (pr_q == ph_q - PW'(1)) ? '0 : pr_q + PW'(1);
    assign row_idx_d = row_idx_q + RW'(1);

    // In IDLE the tiler sees the incoming config so row 0 can be registered
    // on the accepting edge; in RUN it sees the latched config and next row.
    always_comb begin
        src_pat = pat_q;
        src_w   = pw_q;
        src_pr  = pr_d;
        if (state_q == S_IDLE) begin
            src_pat = pattern;
            src_w   = pattern_w;
            src_pr  = '0;
        end
    end

    generate
        for (genvar gi = 0; gi < PAT_MAX; gi++) begin : g_pat_row
            assign pat_row[gi] = src_pat[gi*PAT_MAX +: PAT_MAX];
        end
    endgenerate

    always_comb begin
        src_row = '0;
        for (int r = 0; r < PAT_MAX; r++) begin
            if (src_pr == PW'(r)) src_row = pat_row[r];
        end
    end

    // One fully tiled candidate per legal width; column index is a constant.
    generate
        for (genvar gw = 0; gw < PAT_MAX; gw++) begin : g_width
            for (genvar gi = 0; gi < IMG_W; gi++) begin : g_col
                assign tile_w[gw][gi] = src_row[gi % (gw + 1)];
            end
        end
    endgenerate

    always_comb begin
        mask_d = '0;
        for (int w = 0; w < PAT_MAX; w++) begin
            if (src_w == PW'(w + 1)) mask_d = tile_w[w];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pat_q     <= '0;
            pw_q      <= '0;
            ph_q      <= '0;
            pr_q      <= '0;
            rows_q    <= '0;
            row_idx_q <= '0;
            mask_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
        end else if (clk_en) begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cfg_fire) begin
                        if (cfg_legal) begin
                            state_q   <= S_RUN;
                            pat_q     <= pattern;
                            pw_q      <= pattern_w;
                            ph_q      <= pattern_h;
                            rows_q    <= repeat_rows;
                            pr_q      <= '0;
                            row_idx_q <= '0;
                            mask_q    <= mask_d;
                            valid_q   <= 1'b1;
                            last_q    <= (repeat_rows == RW'(1));
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (row_fire) begin
                        if (last_q) begin
                            state_q   <= S_IDLE;
                            pr_q      <= '0;
                            row_idx_q <= '0;
                            mask_q    <= '0;
                            valid_q   <= 1'b0;
                            last_q    <= 1'b0;
                        end else begin
                            pr_q      <= pr_d;
                            row_idx_q <= row_idx_d;
                            mask_q    <= mask_d;
                            last_q    <= (row_idx_d == rows_q - RW'(1));
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cfg_ready   = (state_q == S_IDLE);
    assign cfg_err     = err_q;
    assign rp_mask_bit = mask_q;
    assign rp_valid    = valid_q;
    assign rp_last     = last_q;
    assign rp_row_idx  = row_idx_q;

endmodule

// File: tb/tb_repeated_mask_gen.sv
// Directed bench for repeated_mask_gen: table of configs with hand-tiled rows,
// plus random-stall, mid-frame reset and single-row back-to-back sequences.
module tb_repeated_mask_gen;

    logic         clk;
    logic         rst_n;
    logic         clk_en;
    logic         cfg_valid;
    logic [2:0]   pattern_w;
    logic [2:0]   pattern_h;
    logic [24:0]  pattern;
    logic [8:0]   repeat_rows;
    logic         cfg_ready;
    logic         cfg_err;
    logic [299:0] rp_mask_bit;
    logic         rp_valid;
    logic         rp_last;
    logic [8:0]   rp_row_idx;
    logic         rp_ready;

    int vectors;
    int miscompares;

    repeated_mask_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_en      (clk_en),
        .cfg_valid   (cfg_valid),
        .pattern_w   (pattern_w),
        .pattern_h   (pattern_h),
        .pattern     (pattern),
        .repeat_rows (repeat_rows),
        .cfg_ready   (cfg_ready),
        .cfg_err     (cfg_err),
        .rp_mask_bit (rp_mask_bit),
        .rp_valid    (rp_valid),
        .rp_last     (rp_last),
        .rp_row_idx  (rp_row_idx),
        .rp_ready    (rp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           w;
        int           h;
        logic [24:0]  pat;
        int           rows;
        bit           legal;
        logic [299:0] ev;
        logic [299:0] od;
    } vec_t;

    vec_t tbl [11];

    task automatic chk_w(input string name, input logic [299:0] act, input logic [299:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_n(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [299:0] model_row(input logic [24:0] p, input int w, input int h, input int i);
        logic [299:0] r;
        int pr;
        pr = i % h;
        for (int j = 0; j < 300; j++) r[j] = p[pr*5 + (j % w)];
        return r;
    endfunction

    task automatic chk_idle(input string tag);
        chk_n({tag, "_cfg_ready"}, int'(cfg_ready), 1);
        chk_n({tag, "_rp_valid"}, int'(rp_valid), 0);
        chk_n({tag, "_rp_last"}, int'(rp_last), 0);
        chk_n({tag, "_rp_row_idx"}, int'(rp_row_idx), 0);
        chk_w({tag, "_rp_mask_bit"}, rp_mask_bit, '0);
    endtask

    // Called at a negedge while idle; returns at the negedge after the final handshake.
    task automatic run_frame(input int w, input int h, input logic [24:0] pat, input int rows,
                             input logic [299:0] ev, input logic [299:0] od,
                             input bit use_model, input bit rnd);
        int cnt;
        int cyc;
        int budget;
        bit hs;
        logic [299:0] exp;
        pattern_w   = 3'(w);
        pattern_h   = 3'(h);
        pattern     = pat;
        repeat_rows = 9'(rows);
        cfg_valid   = 1'b1;
        clk_en      = 1'b1;
        rp_ready    = 1'b0;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk_n("cfg_ready_in_run", int'(cfg_ready), 0);
        if (rnd) begin
            pattern_w = 3'd0;
            pattern   = ~pat;
        end
        cnt    = 0;
        cyc    = 0;
        budget = rows * 20 + 10;
        while (cnt < rows && cyc < budget) begin
            exp = use_model ? model_row(pat, w, h, cnt) : ((cnt % 2) != 0 ? od : ev);
            chk_n("rp_valid", int'(rp_valid), 1);
            chk_n("rp_row_idx", int'(rp_row_idx), cnt);
            chk_n("rp_last", int'(rp_last), (cnt == rows - 1) ? 1 : 0);
            chk_w("rp_mask_bit", rp_mask_bit, exp);
            chk_n("cfg_err_in_run", int'(cfg_err), 0);
            if (rnd) begin
                rp_ready  = ($urandom_range(0, 3) != 0);
                clk_en    = ($urandom_range(0, 4) != 0);
                cfg_valid = $urandom_range(0, 1) != 0;
            end else begin
                rp_ready = 1'b1;
                clk_en   = 1'b1;
            end
            hs = rp_valid && rp_ready && clk_en;
            @(negedge clk);
            if (hs) cnt++;
            cyc++;
        end
        if (cnt < rows) begin
            vectors++;
            miscompares++;
            $display("FAIL frame_timeout: got %0d handshakes expected %0d", cnt, rows);
        end
        cfg_valid = 1'b0;
        clk_en    = 1'b1;
        rp_ready  = 1'b0;
        chk_idle("end_of_frame");
        $display("frame w=%0d h=%0d rows=%0d: %0d handshakes in %0d cycles", w, h, rows, cnt, cyc);
    endtask

    task automatic illegal_cfg(input vec_t v);
        pattern_w   = 3'(v.w);
        pattern_h   = 3'(v.h);
        pattern     = v.pat;
        repeat_rows = 9'(v.rows);
        cfg_valid   = 1'b1;
        clk_en      = 1'b1;
        rp_ready    = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk_n("cfg_err_pulse", int'(cfg_err), 1);
        chk_n("illegal_rp_valid", int'(rp_valid), 0);
        chk_n("illegal_cfg_ready", int'(cfg_ready), 1);
        @(negedge clk);
        chk_n("cfg_err_clear", int'(cfg_err), 0);
        chk_n("illegal_rp_valid2", int'(rp_valid), 0);
        $display("illegal cfg w=%0d h=%0d rows=%0d rejected", v.w, v.h, v.rows);
    endtask

    initial begin
        logic [24:0] rpat;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        clk_en      = 1'b1;
        cfg_valid   = 1'b0;
        pattern_w   = '0;
        pattern_h   = '0;
        pattern     = '0;
        repeat_rows = '0;
        rp_ready    = 1'b0;

        tbl[0]  = '{4, 1, 25'h000000A, 3, 1'b1, {75{4'b1010}}, {75{4'b1010}}};
        tbl[1]  = '{3, 2, 25'h00000C1, 5, 1'b1, {100{3'b001}}, {100{3'b110}}};
        tbl[2]  = '{5, 2, 25'h0000193, 4, 1'b1, {60{5'b10011}}, {60{5'b01100}}};
        tbl[3]  = '{3, 1, 25'h1FFFFFA, 2, 1'b1, {100{3'b010}}, {100{3'b010}}};
        tbl[4]  = '{4, 1, 25'h1FFFFFA, 2, 1'b1, {75{4'b1010}}, {75{4'b1010}}};
        tbl[5]  = '{1, 1, 25'h0000001, 2, 1'b1, {300{1'b1}}, {300{1'b1}}};
        tbl[6]  = '{2, 2, 25'h1FFFFBE, 3, 1'b1, {150{2'b10}}, {150{2'b01}}};
        tbl[7]  = '{0, 1, 25'h0000001, 3, 1'b0, '0, '0};
        tbl[8]  = '{2, 6, 25'h0000001, 3, 1'b0, '0, '0};
        tbl[9]  = '{2, 1, 25'h0000001, 0, 1'b0, '0, '0};
        tbl[10] = '{2, 1, 25'h0000001, 301, 1'b0, '0, '0};

        repeat (3) @(negedge clk);
        chk_idle("in_reset");
        chk_n("in_reset_cfg_err", int'(cfg_err), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("after_reset");

        for (int k = 0; k < 11; k++) begin
            if (tbl[k].legal)
                run_frame(tbl[k].w, tbl[k].h, tbl[k].pat, tbl[k].rows, tbl[k].ev, tbl[k].od, 1'b0, 1'b0);
            else
                illegal_cfg(tbl[k]);
        end

        // 5x5 random pattern, full-height frame, random stalls and clock enable
        rpat = 25'($urandom);
        run_frame(5, 5, rpat, 300, '0, '0, 1'b1, 1'b1);

        // Reset in the middle of a frame
        pattern_w   = 3'd2;
        pattern_h   = 3'd1;
        pattern     = 25'h0000002;
        repeat_rows = 9'd300;
        cfg_valid   = 1'b1;
        clk_en      = 1'b1;
        rp_ready    = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk_n("midframe_row_idx", int'(rp_row_idx), 10);
        chk_w("midframe_mask", rp_mask_bit, {150{2'b10}});
        rst_n = 1'b0;
        #1;
        chk_idle("async_reset");
        chk_n("async_reset_cfg_err", int'(cfg_err), 0);
        @(negedge clk);
        rst_n    = 1'b1;
        rp_ready = 1'b0;
        @(negedge clk);
        chk_idle("post_reset_idle");
        $display("mid-frame reset after row 10 done");
        run_frame(2, 1, 25'h0000001, 3, {150{2'b01}}, {150{2'b01}}, 1'b0, 1'b0);

        // Single-row frames back to back
        run_frame(4, 1, 25'h000000A, 1, {75{4'b1010}}, {75{4'b1010}}, 1'b0, 1'b0);
        run_frame(4, 1, 25'h0000005, 1, {75{4'b0101}}, {75{4'b0101}}, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
